// File: rtl/leaky_mac_pkg.sv
// leaky_mac_pkg: shared widths and helpers for the leaky multi-channel MAC
package leaky_mac_pkg;
   localparam int default_width = 10;
   localparam int acc_w = 2 * default_width;
   typedef logic [acc_w-1:0] acc_t;
   function automatic int chan_w(input int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/leaky_mac_mc_leak_scale.sv
// leak_scale: combinational leak multiply, shift, add and overflow handling
module leak_scale #(
   parameter int width_p = 10,
   parameter int coeff_num_p = 27,
   parameter int coeff_shift_p = 5,
   parameter int saturate_p = 1
) (
   input  logic [2*width_p-1:0] acc,
   input  logic [width_p-1:0]   data,
   input  logic                 clear,
   output logic [2*width_p-1:0] result,
   output logic                 ovf
);
   localparam int aw = 2 * width_p;
   localparam int iw = aw + coeff_shift_p + 1;
   logic [iw-1:0] prod, sum;
   always_comb begin
      prod = iw'(acc) * iw'(coeff_num_p);
      sum = (clear ? '0 : prod >> coeff_shift_p) + iw'(data);
      ovf = |sum[iw-1:aw];
      result = (ovf && saturate_p != 0) ? '1 : sum[aw-1:0];
   end
endmodule

// File: rtl/leaky_mac_mc.sv
// leaky_mac_mc: per-channel leaky accumulator behind a one-entry elastic output stage
module leaky_mac_mc
   import leaky_mac_pkg::*;
#(
   parameter int width_p = 10,
   parameter int channels_p = 4,
   parameter int coeff_num_p = 27,
   parameter int coeff_shift_p = 5,
   parameter int saturate_p = 1,
   localparam int cw = chan_w(channels_p),
   localparam int aw = 2 * width_p
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic [width_p-1:0] data_i,
   input  logic [cw-1:0]      chan_i,
   input  logic               clear_i,
   input  logic               valid_i,
   output logic               ready_o,
   output logic               valid_o,
   output logic [aw-1:0]      data_o,
   output logic [cw-1:0]      chan_o,
   output logic               sat_o,
   input  logic               ready_i
);
   logic [aw-1:0] acc_q [channels_p];
   logic [aw-1:0] result;
   logic in_range, ovf, accept;
   assign in_range = 32'(chan_i) < channels_p;
   assign ready_o = ~valid_o | ready_i;
   assign accept = valid_i & ready_o;
   // an unmapped channel passes its sample straight through as a cleared accumulate
   leak_scale #(
      .width_p(width_p),
      .coeff_num_p(coeff_num_p),
      .coeff_shift_p(coeff_shift_p),
      .saturate_p(saturate_p)
   ) u_scale (
      .acc(acc_q[chan_i]),
      .data(data_i),
      .clear(clear_i | ~in_range),
      .result(result),
      .ovf(ovf)
   );
   always_ff @(posedge clk_i or posedge reset_i)
      if (reset_i) begin
         valid_o <= 1'b0;
         data_o <= '0;
         chan_o <= '0;
         sat_o <= 1'b0;
         for (int i = 0; i < channels_p; i++) acc_q[i] <= '0;
      end else if (accept) begin
         valid_o <= 1'b1;
         data_o <= result;
         chan_o <= chan_i;
         sat_o <= ovf;
         for (int i = 0; i < channels_p; i++) if (chan_i == cw'(i)) acc_q[i] <= result;
      end else if (ready_i)
         valid_o <= 1'b0;
endmodule

// File: tb/tb_leaky_mac_mc.sv
// tb_leaky_mac_mc: table plus scoreboard checks for the leaky multi-channel MAC
module tb_leaky_mac_mc;
   logic clk = 1'b0, rst;
   always #5 clk = ~clk;
   logic [9:0] data_i;
   logic [1:0] chan_i, chan_o;
   logic clear_i, valid_i, ready_i, ready_o, valid_o, sat_o;
   logic [19:0] data_o;
   logic [3:0] s_data;
   logic [1:0] s_chan, s_ch_a, s_ch_b;
   logic s_clr, s_valid, s_rdy_a, s_rdy_b, s_val_a, s_val_b, s_sat_a, s_sat_b;
   logic [7:0] s_do_a, s_do_b;
   typedef struct {
      logic [9:0] d;
      logic [1:0] c;
      logic clr;
      logic [19:0] ed;
      logic es;
   } vec_t;
   typedef struct packed {
      logic [19:0] d;
      logic [1:0] c;
      logic s;
   } exp_t;
   exp_t q[$];
   vec_t vt[9];
   int checks = 0, failures = 0;
   leaky_mac_mc dut (
      .clk_i(clk), .reset_i(rst), .data_i(data_i), .chan_i(chan_i), .clear_i(clear_i),
      .valid_i(valid_i), .ready_o(ready_o), .valid_o(valid_o), .data_o(data_o),
      .chan_o(chan_o), .sat_o(sat_o), .ready_i(ready_i)
   );
   leaky_mac_mc #(.width_p(4), .channels_p(3), .coeff_num_p(32), .coeff_shift_p(5), .saturate_p(1)) dut_sat (
      .clk_i(clk), .reset_i(rst), .data_i(s_data), .chan_i(s_chan), .clear_i(s_clr),
      .valid_i(s_valid), .ready_o(s_rdy_a), .valid_o(s_val_a), .data_o(s_do_a),
      .chan_o(s_ch_a), .sat_o(s_sat_a), .ready_i(1'b1)
   );
   leaky_mac_mc #(.width_p(4), .channels_p(3), .coeff_num_p(32), .coeff_shift_p(5), .saturate_p(0)) dut_wrap (
      .clk_i(clk), .reset_i(rst), .data_i(s_data), .chan_i(s_chan), .clear_i(s_clr),
      .valid_i(s_valid), .ready_o(s_rdy_b), .valid_o(s_val_b), .data_o(s_do_b),
      .chan_o(s_ch_b), .sat_o(s_sat_b), .ready_i(1'b1)
   );
   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask
   always @(negedge clk)
      if (!rst && valid_o && ready_i) begin
         exp_t e;
         if (q.size() == 0) chk("unexpected_output", 1, 0);
         else begin
            e = q.pop_front();
            chk("data_o", longint'(data_o), longint'(e.d));
            chk("chan_o", longint'(chan_o), longint'(e.c));
            chk("sat_o", longint'(sat_o), longint'(e.s));
         end
      end
   task automatic send(input logic [9:0] d, input logic [1:0] c, input logic clr,
                       input logic [19:0] ed, input logic es);
      int n = 0;
      data_i = d;
      chan_i = c;
      clear_i = clr;
      valid_i = 1'b1;
      @(negedge clk);
      while (!ready_o && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!ready_o) chk("accept_timeout", 0, 1);
      else q.push_back('{ed, c, es});
      @(posedge clk);
      #1 valid_i = 1'b0;
   endtask
   initial begin
      int m;
      vt[0] = '{10'd100, 2'd0, 1'b0, 20'd100, 1'b0};
      vt[1] = '{10'd100, 2'd0, 1'b0, 20'd184, 1'b0};
      vt[2] = '{10'd7, 2'd1, 1'b0, 20'd7, 1'b0};
      vt[3] = '{10'd0, 2'd0, 1'b0, 20'd155, 1'b0};
      vt[4] = '{10'd5, 2'd0, 1'b1, 20'd5, 1'b0};
      vt[5] = '{10'd0, 2'd1, 1'b0, 20'd5, 1'b0};
      vt[6] = '{10'd1023, 2'd3, 1'b0, 20'd1023, 1'b0};
      vt[7] = '{10'd1023, 2'd3, 1'b0, 20'd1886, 1'b0};
      vt[8] = '{10'd0, 2'd2, 1'b0, 20'd0, 1'b0};
      rst = 1'b1;
      data_i = '0; chan_i = '0; clear_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
      s_data = '0; s_chan = '0; s_clr = 1'b0; s_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_valid_o", longint'(valid_o), 0);
      chk("reset_data_o", longint'(data_o), 0);
      chk("reset_chan_o", longint'(chan_o), 0);
      chk("reset_sat_o", longint'(sat_o), 0);
      chk("reset_small_valid", longint'(s_val_a), 0);
      rst = 1'b0;
      for (int i = 0; i < 9; i++) send(vt[i].d, vt[i].c, vt[i].clr, vt[i].ed, vt[i].es);
      repeat (2) @(posedge clk);
      #1 ready_i = 1'b0;
      send(10'd50, 2'd2, 1'b0, 20'd50, 1'b0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("stall_ready_o", longint'(ready_o), 0);
         chk("stall_valid_o", longint'(valid_o), 1);
         chk("stall_data_o", longint'(data_o), 50);
      end
      @(posedge clk);
      #1 ready_i = 1'b1;
      send(10'd10, 2'd2, 1'b0, 20'd52, 1'b0);
      repeat (3) @(posedge clk);
      #1 chk("queue_drained", q.size(), 0);
      ready_i = 1'b0;
      send(10'd100, 2'd1, 1'b0, 20'd104, 1'b0);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async_reset_valid_o", longint'(valid_o), 0);
      chk("async_reset_data_o", longint'(data_o), 0);
      q.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      ready_i = 1'b1;
      send(10'd100, 2'd0, 1'b0, 20'd100, 1'b0);
      send(10'd100, 2'd1, 1'b0, 20'd100, 1'b0);
      repeat (3) @(posedge clk);
      #1 chk("queue_drained_after_reset", q.size(), 0);
      s_valid = 1'b1;
      s_data = 4'd15;
      m = 0;
      for (int k = 1; k <= 18; k++) begin
         @(posedge clk);
         #1 m += 15;
         chk("sat_data", longint'(s_do_a), m > 255 ? 255 : m);
         chk("sat_flag", longint'(s_sat_a), m > 255 ? 1 : 0);
         chk("wrap_data", longint'(s_do_b), m % 256);
         chk("wrap_flag", longint'(s_sat_b), m > 255 ? 1 : 0);
      end
      s_chan = 2'd3;
      s_data = 4'd9;
      @(posedge clk);
      #1;
      chk("oor_data", longint'(s_do_a), 9);
      chk("oor_chan", longint'(s_ch_a), 3);
      chk("oor_sat", longint'(s_sat_a), 0);
      chk("oor_wrap_data", longint'(s_do_b), 9);
      s_chan = 2'd0;
      s_data = 4'd0;
      @(posedge clk);
      #1;
      chk("sat_hold_data", longint'(s_do_a), 255);
      chk("sat_hold_flag", longint'(s_sat_a), 0);
      chk("wrap_hold_data", longint'(s_do_b), 14);
      s_clr = 1'b1;
      s_data = 4'd3;
      @(posedge clk);
      #1;
      chk("sat_clear_data", longint'(s_do_a), 3);
      chk("wrap_clear_data", longint'(s_do_b), 3);
      s_valid = 1'b0;
      s_clr = 1'b0;
      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1);
   end
endmodule
